// File: rtl/seg_disp_pkg.sv
// Shared definitions for the scrolling 7-segment display driver:
// glyph codes, segment bit masks and the glyph-to-segment decoder.
package seg_disp_pkg;

   // Glyph codes beyond the hex digits 0x00..0x0F
   localparam logic [4:0] GLYPH_BLANK = 5'h10;
   localparam logic [4:0] GLYPH_H     = 5'h11;
   localparam logic [4:0] GLYPH_L     = 5'h12;
   localparam logic [4:0] GLYPH_P     = 5'h13;
   localparam logic [4:0] GLYPH_DASH  = 5'h14;
   localparam logic [4:0] GLYPH_O     = 5'h15;
   localparam logic [4:0] GLYPH_C     = 5'h16;
   localparam logic [4:0] GLYPH_E     = 5'h17;

   // Segment masks within the 7-bit {a,b,c,d,e,f,g} vector
   localparam logic [6:0] SEG_A = 7'b1000000;
   localparam logic [6:0] SEG_B = 7'b0100000;
   localparam logic [6:0] SEG_C = 7'b0010000;
   localparam logic [6:0] SEG_D = 7'b0001000;
   localparam logic [6:0] SEG_E = 7'b0000100;
   localparam logic [6:0] SEG_F = 7'b0000010;
   localparam logic [6:0] SEG_G = 7'b0000001;

   // Decimal point position in the 8-bit cathode word {a..g,dp}
   localparam int CATHODE_DP_BIT = 0;

   // Glyph code to lit segments; unknown codes render blank
   function automatic logic [6:0] seg7(input logic [4:0] code);
      logic [6:0] s;
      s = '0;
      case (code)
         5'h00:       s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
         5'h01:       s = SEG_B | SEG_C;
         5'h02:       s = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
         5'h03:       s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
         5'h04:       s = SEG_B | SEG_C | SEG_F | SEG_G;
         5'h05:       s = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
         5'h06:       s = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
         5'h07:       s = SEG_A | SEG_B | SEG_C;
         5'h08:       s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
         5'h09:       s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
         5'h0A:       s = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
         5'h0B:       s = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
         5'h0C:       s = SEG_A | SEG_D | SEG_E | SEG_F;
         5'h0D:       s = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
         5'h0E:       s = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
         5'h0F:       s = SEG_A | SEG_E | SEG_F | SEG_G;
         GLYPH_H:     s = SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
         GLYPH_L:     s = SEG_D | SEG_E | SEG_F;
         GLYPH_P:     s = SEG_A | SEG_B | SEG_E | SEG_F | SEG_G;
         GLYPH_DASH:  s = SEG_G;
         GLYPH_O:     s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
         GLYPH_C:     s = SEG_A | SEG_D | SEG_E | SEG_F;
         GLYPH_E:     s = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
         default:     s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scroll_display_prescaler.sv
// Generic enable-gated modulo-DIV counter. tick is high on the enabled
// cycle that completes a period; clr holds the count at zero.
module seg_prescaler
   import seg_disp_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Count enabled events, wrapping after DIV of them
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scroll_display.sv
// Multiplexed 7-segment driver showing a scrolling DIGITS-wide window
// of a writable MSG_LEN-character message, with selectable pin polarity.
module seg_scroll_display
   import seg_disp_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int MSG_LEN     = 16,
   parameter int REFRESH_DIV = 50000,
   parameter int SCROLL_DIV  = 100,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       wr_en,
   input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
   input  logic [5:0]                 wr_data,
   input  logic                       scroll_en,
   input  logic                       dir,
   input  logic                       blank,
   output logic [7:0]                 cathodes,
   output logic [DIGITS-1:0]          anodes,
   output logic                       frame_tick
);

   localparam int                AW         = $clog2(MSG_LEN);
   localparam int                DW         = $clog2(DIGITS);
   localparam logic [DW-1:0]     DIG_LAST   = DW'(DIGITS - 1);
   localparam logic [AW-1:0]     OFF_LAST   = AW'(MSG_LEN - 1);
   localparam logic [AW:0]       MSG_LEN_W  = (AW + 1)'(MSG_LEN);
   localparam logic [DIGITS-1:0] LEFT_DIGIT = {1'b1, {(DIGITS - 1){1'b0}}};

   logic              digit_tick;
   logic              scroll_tick;
   logic              frame_end;
   logic [DW-1:0]     dig;
   logic [AW-1:0]     offset;
   logic [AW-1:0]     offset_next;
   logic [5:0]        msg [MSG_LEN];
   logic              wr_ok;
   logic [AW:0]       idx_sum;
   logic [AW-1:0]     idx;
   logic [5:0]        cur;
   logic [DIGITS-1:0] anodes_r;
   logic [7:0]        cathodes_r;

   // Digit slot timer: one tick every REFRESH_DIV clocks
   seg_prescaler #(.DIV(REFRESH_DIV)) u_refresh (
      .clk  (clk),
      .nrst (nrst),
      .en   (1'b1),
      .clr  (1'b0),
      .tick (digit_tick)
   );

   assign frame_end = digit_tick && (dig == DIG_LAST);

   // Scroll step timer: counts whole frames, parked at zero while scrolling is off
   seg_prescaler #(.DIV(SCROLL_DIV)) u_scroll (
      .clk  (clk),
      .nrst (nrst),
      .en   (frame_end && scroll_en),
      .clr  (!scroll_en),
      .tick (scroll_tick)
   );

   // Active digit index, advancing once per slot
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dig <= '0;
      end else if (digit_tick) begin
         dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end
   end

   // Next window offset, explicit wrap so MSG_LEN need not be a power of two
   // NOTE: offset_next is assigned before any branch so no latch is inferred.
   always_comb begin
      offset_next = offset;
      if (scroll_tick) begin
         if (dir) begin
            offset_next = (offset == '0) ? OFF_LAST : offset - 1'b1;
         end else begin
            offset_next = (offset == OFF_LAST) ? '0 : offset + 1'b1;
         end
      end
   end

   // Window offset register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         offset <= '0;
      end else begin
         offset <= offset_next;
      end
   end

   assign wr_ok = (32'(wr_addr) < 32'(MSG_LEN));

   // Message buffer, one character written per strobe
   // NOTE: the buffer is flops, not RAM, because reset must blank every entry at once.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            msg[i] <= {1'b0, GLYPH_BLANK};
         end
      end else if (wr_en && wr_ok) begin
         msg[wr_addr] <= wr_data;
      end
   end

   // Character under the active digit: (offset + dig) mod MSG_LEN
   assign idx_sum = {1'b0, offset} + (AW + 1)'(dig);
   assign idx     = (idx_sum >= MSG_LEN_W) ? AW'(idx_sum - MSG_LEN_W) : idx_sum[AW-1:0];
   assign cur     = msg[idx];

   // Output registers reload every cycle; frame_tick marks the end of the last slot
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         anodes_r   <= '0;
         cathodes_r <= '0;
         frame_tick <= 1'b0;
      end else begin
         anodes_r   <= blank ? '0 : (LEFT_DIGIT >> dig);
         cathodes_r <= {seg7(cur[4:0]), cur[5]};
         frame_tick <= frame_end;
      end
   end

   assign anodes   = anodes_r ^ {DIGITS{ACTIVE_LOW}};
   assign cathodes = cathodes_r ^ {8{ACTIVE_LOW}};

endmodule

// File: doc/seg_scroll_display.md
Name: seg_scroll_display

Overview:
Parametrised multiplexed 7-segment display driver. It holds a writable message of MSG_LEN characters and time-multiplexes a DIGITS-wide window of that message onto the common anode/cathode lines. It scrolls the window left or right at a programmable rate. Output polarity is set by a parameter instead of a compile-time define. It sits between board-level control logic and the display pins, and supersedes the fixed-text, fixed-width display blocks.

Parameters:
DIGITS, 8, number of physical digits (anodes width); legal 2..16
MSG_LEN, 16, message buffer depth in characters; must be >= DIGITS
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2
SCROLL_DIV, 100, complete refresh frames per scroll step; must be >= 1
ACTIVE_LOW, 1, 1 = anodes and cathodes driven inverted at the pins; 0 = true polarity

Ports:
clk  in  1  system clock, all state on rising edge
nrst  in  1  asynchronous active-low reset
wr_en  in  1  message write strobe, one character per cycle
wr_addr  in  $clog2(MSG_LEN)  character index to write
wr_data  in  6  [5] = decimal point, [4:0] = glyph code
scroll_en  in  1  1 = scrolling enabled
dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1)
blank  in  1  1 = all anodes inactive; counters keep running
cathodes  out  8  segments {a,b,c,d,e,f,g,dp}; bit7 = a, bit0 = dp
anodes  out  DIGITS  one-hot digit select; bit DIGITS-1 = leftmost digit (digit 0)
frame_tick  out  1  one-cycle pulse at the end of each full frame

Behaviour:
- Reset (async, nrst low): pre_cnt=0, dig=0, frame_cnt=0, offset=0, all message entries = blank glyph 0x10 with dp=0, anodes_r=0, cathodes_r=0, frame_tick=0.
- Pin values during reset: ACTIVE_LOW=1 gives anodes all 1 and cathodes 8'hFF. ACTIVE_LOW=0 gives all 0.
- Prescaler: pre_cnt counts 0..REFRESH_DIV-1 and wraps. digit_tick = (pre_cnt == REFRESH_DIV-1).
- On digit_tick, dig advances and wraps from DIGITS-1 to 0.
- frame_tick is registered. It is 1 in the cycle after the edge where digit_tick && dig == DIGITS-1.
- Scroll, scroll_en=1: on each frame end (digit_tick && dig == DIGITS-1), frame_cnt increments.
- When frame_cnt == SCROLL_DIV-1 at a frame end, frame_cnt clears and offset steps by one. Left is (offset+1) mod MSG_LEN; right is (offset+MSG_LEN-1) mod MSG_LEN.
- Offset arithmetic is explicit compare-and-wrap; MSG_LEN need not be a power of 2.
- Scroll, scroll_en=0: frame_cnt is held at 0 and offset is frozen. A dir change takes effect at the next step.
- Display character: idx = (offset + dig) mod MSG_LEN, ch = msg[idx].
- Output registers load every cycle, giving 1-cycle latency from any state or input change:
  - anodes_r = blank ? 0 : (1 << (DIGITS-1-dig))
  - cathodes_r = {seg7(ch[4:0]), ch[5]}
- Pins: anodes = anodes_r ^ {DIGITS{ACTIVE_LOW}}; cathodes = cathodes_r ^ {8{ACTIVE_LOW}}.
- Writes: msg[wr_addr] <= wr_data on an edge with wr_en=1.
  - wr_addr >= MSG_LEN is ignored.
  - Writing the character currently displayed appears on cathodes one cycle after the write edge. The write has priority; there is no tearing beyond that.
- Glyph codes: 0x00-0x0F hex 0-F (b and d lowercase); 0x10 blank; 0x11 H; 0x12 L; 0x13 P; 0x14 dash (g only); 0x15 O; 0x16 C; 0x17 E. All others are blank.
- Reset mid-operation clears all state, including the message buffer, immediately. After nrst rises, the first clock edge loads digit 0.

Decomposition:
- Package seg_disp_pkg:
  - glyph code localparams (GLYPH_BLANK=5'h10, GLYPH_H, ...)
  - function seg7(input [4:0]) returning 7 bits {a..g}
  - segment bit-order constants
- Sub-module seg_prescaler:
  - parameter DIV; ports clk, nrst, en, tick
  - used twice: for the digit slot (en=1) and for the scroll step (en = frame end with scroll_en; DIV=SCROLL_DIV, cleared when scroll_en=0 via its en/clear input)

Test Plan:
All scenarios use DIGITS=4, MSG_LEN=6, REFRESH_DIV=4, SCROLL_DIV=2, ACTIVE_LOW=0.
1. Reset, then write codes 0..5 with scroll_en=0 -> anodes cycle 4'b1000, 0100, 0010, 0001, each held 4 cycles. Cathodes per slot are 0xFC ('0'), 0x60 ('1'), 0xDA ('2'), 0xF2 ('3'). frame_tick pulses every 16 cycles.
2. scroll_en=1, dir=0 from offset 0 -> after 2 frames (32 cycles) digit 0 shows '1' (0x60). After 10 frames (offset 5) the digits show 5,0,1,2, i.e. wrap-around.
3. dir=1 from offset 0 -> one step gives offset 5, and digit 0 shows '5' (0xB6).
4. Write 6'h2A (dp set, glyph 'A') to the address currently displayed -> the next cycle shows cathodes 0xEF. A write with wr_addr=7 leaves all entries unchanged.
5. blank=1 mid-frame -> anodes are 0 one cycle later, and frame_tick cadence is unchanged. Deassert mid-scroll-period, then nrst pulse -> all outputs 0, offset 0, message all blank.
6. Rebuild with ACTIVE_LOW=1 -> in reset, anodes=4'hF and cathodes=8'hFF. The digit 0 slot showing '0' gives anodes=4'b0111 and cathodes=0x03.
